axi4_rd_packet_fifo_credit: RTL and testbench

Single-clock AXI4 read-channel packet FIFO that sits between an upstream AXI4 read master (slaver side) and a downstream read slave/interconnect (master side). It buffers AR requests and R beats. It forwards an AR downstream only after reserving buffer space for the whole burst, so the downstream R channel is never back-pressured. It also offers cut-through or store-and-forward release of R bursts and a sticky RID-order check.

---
 rtl/axi4_rd_packet_fifo_credit.sv | 163 ++++++++++++++++
 tb/tb_axi4_rd_packet_fifo_credit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_packet_fifo_credit.sv
// AXI4 read-channel packet FIFO: AR requests are forwarded downstream only once the whole
// burst has reserved space in the R data FIFO, so the downstream R channel never stalls.
module axi4_rd_packet_fifo_credit #(
    parameter int    IDSIZE     = 4,
    parameter int    ASIZE      = 32,
    parameter int    LSIZE      = 8,
    parameter int    DSIZE      = 32,
    parameter int    AR_DEPTH   = 4,
    parameter int    DATA_DEPTH = 256,
    parameter string MODE       = "CUT",
    localparam int   CW         = $clog2(DATA_DEPTH) + 1,
    localparam int   OW         = $clog2(AR_DEPTH) + 1
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic [ASIZE-1:0]  slaver_axi_araddr,
    input  logic [LSIZE-1:0]  slaver_axi_arlen,
    input  logic [IDSIZE-1:0] slaver_axi_arid,
    input  logic              slaver_axi_arvalid,
    output logic              slaver_axi_arready,
    output logic [DSIZE-1:0]  slaver_axi_rdata,
    output logic [IDSIZE-1:0] slaver_axi_rid,
    output logic              slaver_axi_rlast,
    output logic              slaver_axi_rvalid,
    input  logic              slaver_axi_rready,
    output logic [ASIZE-1:0]  master_axi_araddr,
    output logic [LSIZE-1:0]  master_axi_arlen,
    output logic [IDSIZE-1:0] master_axi_arid,
    output logic              master_axi_arvalid,
    input  logic              master_axi_arready,
    input  logic [DSIZE-1:0]  master_axi_rdata,
    input  logic [IDSIZE-1:0] master_axi_rid,
    input  logic              master_axi_rlast,
    input  logic              master_axi_rvalid,
    output logic              master_axi_rready,
    output logic [CW-1:0]     free_credits,
    output logic [OW-1:0]     outstanding,
    output logic              len_err,
    output logic              id_err
);
    localparam int AAW = $clog2(AR_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int NW  = ((LSIZE > CW) ? LSIZE : CW) + 1;
    localparam int BW  = OW + DAW;
    localparam int ARW = ASIZE + LSIZE + IDSIZE;
    localparam int RW  = DSIZE + IDSIZE + 1;
    localparam bit STORE_MODE = (MODE == "STORE");
    localparam logic [AAW:0] PA1 = 1;
    localparam logic [DAW:0] PD1 = 1;

    logic [ARW-1:0]    ar_mem  [AR_DEPTH];
    logic [IDSIZE-1:0] idq_mem [AR_DEPTH];
    logic [RW-1:0]     d_mem   [DATA_DEPTH];

    logic [AAW:0]  ar_wp_q, ar_wp_d, ar_rp_q, ar_rp_d;
    logic [AAW:0]  idq_wp_q, idq_wp_d, idq_rp_q, idq_rp_d;
    logic [DAW:0]  d_wp_q, d_wp_d, d_rp_q, d_rp_d;
    logic [CW-1:0] free_q, free_d;
    logic [OW-1:0] out_q, out_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          len_err_q, len_err_d, id_err_q, id_err_d, rdy_en_q, rdy_en_d;

    logic [ASIZE-1:0]  h_addr;
    logic [LSIZE-1:0]  h_len;
    logic [IDSIZE-1:0] h_id, idq_head, h_rid;
    logic [DSIZE-1:0]  h_rdata;
    logic              h_rlast;
    logic [NW-1:0]     need;
    logic              ar_full, ar_empty, d_full, d_empty, ar_issue, r_avail;
    logic              s_ar_hs, m_ar_hs, m_r_hs, s_r_hs;

    assign {h_addr, h_len, h_id}     = ar_mem[ar_rp_q[AAW-1:0]];
    assign {h_rdata, h_rid, h_rlast} = d_mem[d_rp_q[DAW-1:0]];
    assign idq_head = idq_mem[idq_rp_q[AAW-1:0]];

    assign ar_empty = (ar_wp_q == ar_rp_q);
    assign ar_full  = (ar_wp_q[AAW] != ar_rp_q[AAW]) && (ar_wp_q[AAW-1:0] == ar_rp_q[AAW-1:0]);
    assign d_empty  = (d_wp_q == d_rp_q);
    assign d_full   = (d_wp_q[DAW] != d_rp_q[DAW]) && (d_wp_q[DAW-1:0] == d_rp_q[DAW-1:0]);

    // Issue decision depends only on registered state, never on master_axi_arready.
    assign need     = NW'(h_len) + NW'(1);
    assign ar_issue = !ar_empty && (NW'(free_q) >= need) && (out_q < OW'(AR_DEPTH));
    assign r_avail  = !d_empty && (!STORE_MODE || (cnt_q != '0));

    assign slaver_axi_arready = rdy_en_q && !ar_full;
    assign master_axi_rready  = rdy_en_q && !d_full;
    assign master_axi_arvalid = ar_issue;
    assign master_axi_araddr  = ar_issue ? h_addr : '0;
    assign master_axi_arlen   = ar_issue ? h_len  : '0;
    assign master_axi_arid    = ar_issue ? h_id   : '0;
    assign slaver_axi_rvalid  = r_avail;
    assign slaver_axi_rdata   = r_avail ? h_rdata : '0;
    assign slaver_axi_rid     = r_avail ? h_rid   : '0;
    assign slaver_axi_rlast   = r_avail && h_rlast;
    assign free_credits = free_q;
    assign outstanding  = out_q;
    assign len_err      = len_err_q;
    assign id_err       = id_err_q;

    assign s_ar_hs = slaver_axi_arvalid && slaver_axi_arready;
    assign m_ar_hs = master_axi_arvalid && master_axi_arready;
    assign m_r_hs  = master_axi_rvalid && master_axi_rready;
    assign s_r_hs  = slaver_axi_rvalid && slaver_axi_rready;

    always_comb begin
        ar_wp_d   = ar_wp_q;
        ar_rp_d   = ar_rp_q;
        idq_wp_d  = idq_wp_q;
        idq_rp_d  = idq_rp_q;
        d_wp_d    = d_wp_q;
        d_rp_d    = d_rp_q;
        rdy_en_d  = 1'b1;
        if (s_ar_hs)                 ar_wp_d  = ar_wp_q + PA1;
        if (m_ar_hs)                 ar_rp_d  = ar_rp_q + PA1;
        if (m_ar_hs)                 idq_wp_d = idq_wp_q + PA1;
        if (m_r_hs && master_axi_rlast) idq_rp_d = idq_rp_q + PA1;
        if (m_r_hs)                  d_wp_d   = d_wp_q + PD1;
        if (s_r_hs)                  d_rp_d   = d_rp_q + PD1;
        free_d    = free_q + CW'(s_r_hs) - (m_ar_hs ? CW'(need) : {CW{1'b0}});
        out_d     = out_q + OW'(m_ar_hs) - OW'(m_r_hs && master_axi_rlast);
        cnt_d     = cnt_q + BW'(m_r_hs && master_axi_rlast) - BW'(s_r_hs && h_rlast);
        len_err_d = len_err_q | (s_ar_hs && (NW'(slaver_axi_arlen) >= NW'(DATA_DEPTH)));
        id_err_d  = id_err_q | (m_r_hs && (master_axi_rid != idq_head));
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            ar_wp_q   <= '0;
            ar_rp_q   <= '0;
            idq_wp_q  <= '0;
            idq_rp_q  <= '0;
            d_wp_q    <= '0;
            d_rp_q    <= '0;
            free_q    <= CW'(DATA_DEPTH);
            out_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            id_err_q  <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            ar_wp_q   <= ar_wp_d;
            ar_rp_q   <= ar_rp_d;
            idq_wp_q  <= idq_wp_d;
            idq_rp_q  <= idq_rp_d;
            d_wp_q    <= d_wp_d;
            d_rp_q    <= d_rp_d;
            free_q    <= free_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            id_err_q  <= id_err_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge axi_aclk) begin
        if (s_ar_hs) ar_mem[ar_wp_q[AAW-1:0]]   <= {slaver_axi_araddr, slaver_axi_arlen, slaver_axi_arid};
        if (m_ar_hs) idq_mem[idq_wp_q[AAW-1:0]] <= h_id;
        if (m_r_hs)  d_mem[d_wp_q[DAW-1:0]]     <= {master_axi_rdata, master_axi_rid, master_axi_rlast};
    end
endmodule

// File: tb/tb_axi4_rd_packet_fifo_credit.sv
// Directed bench: a default cut-through instance (256 beats) and a small store-and-forward
// instance (16 beats) exercised with burst tables and hand-written corner sequences.
module tb_axi4_rd_packet_fifo_credit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b0, b_rst = 1'b0;

    logic [31:0] a_s_araddr = '0, b_s_araddr = '0;
    logic [7:0]  a_s_arlen = '0, b_s_arlen = '0;
    logic [3:0]  a_s_arid = '0, b_s_arid = '0;
    logic        a_s_arvalid = 1'b0, b_s_arvalid = 1'b0;
    logic        a_s_arready, b_s_arready;
    logic [31:0] a_s_rdata, b_s_rdata;
    logic [3:0]  a_s_rid, b_s_rid;
    logic        a_s_rlast, b_s_rlast, a_s_rvalid, b_s_rvalid;
    logic        a_s_rready = 1'b0, b_s_rready = 1'b0;
    logic [31:0] a_m_araddr, b_m_araddr;
    logic [7:0]  a_m_arlen, b_m_arlen;
    logic [3:0]  a_m_arid, b_m_arid;
    logic        a_m_arvalid, b_m_arvalid;
    logic        a_m_arready = 1'b1, b_m_arready = 1'b1;
    logic [31:0] a_m_rdata = '0, b_m_rdata = '0;
    logic [3:0]  a_m_rid = '0, b_m_rid = '0;
    logic        a_m_rlast = 1'b0, b_m_rlast = 1'b0;
    logic        a_m_rvalid = 1'b0, b_m_rvalid = 1'b0;
    logic        a_m_rready, b_m_rready;
    logic [8:0]  a_free;
    logic [4:0]  b_free;
    logic [2:0]  a_out, b_out;
    logic        a_len_err, b_len_err, a_id_err, b_id_err;

    axi4_rd_packet_fifo_credit u_cut (
        .axi_aclk(clk), .axi_areset(a_rst),
        .slaver_axi_araddr(a_s_araddr), .slaver_axi_arlen(a_s_arlen), .slaver_axi_arid(a_s_arid),
        .slaver_axi_arvalid(a_s_arvalid), .slaver_axi_arready(a_s_arready),
        .slaver_axi_rdata(a_s_rdata), .slaver_axi_rid(a_s_rid), .slaver_axi_rlast(a_s_rlast),
        .slaver_axi_rvalid(a_s_rvalid), .slaver_axi_rready(a_s_rready),
        .master_axi_araddr(a_m_araddr), .master_axi_arlen(a_m_arlen), .master_axi_arid(a_m_arid),
        .master_axi_arvalid(a_m_arvalid), .master_axi_arready(a_m_arready),
        .master_axi_rdata(a_m_rdata), .master_axi_rid(a_m_rid), .master_axi_rlast(a_m_rlast),
        .master_axi_rvalid(a_m_rvalid), .master_axi_rready(a_m_rready),
        .free_credits(a_free), .outstanding(a_out), .len_err(a_len_err), .id_err(a_id_err)
    );

    axi4_rd_packet_fifo_credit #(.DATA_DEPTH(16), .MODE("STORE")) u_st (
        .axi_aclk(clk), .axi_areset(b_rst),
        .slaver_axi_araddr(b_s_araddr), .slaver_axi_arlen(b_s_arlen), .slaver_axi_arid(b_s_arid),
        .slaver_axi_arvalid(b_s_arvalid), .slaver_axi_arready(b_s_arready),
        .slaver_axi_rdata(b_s_rdata), .slaver_axi_rid(b_s_rid), .slaver_axi_rlast(b_s_rlast),
        .slaver_axi_rvalid(b_s_rvalid), .slaver_axi_rready(b_s_rready),
        .master_axi_araddr(b_m_araddr), .master_axi_arlen(b_m_arlen), .master_axi_arid(b_m_arid),
        .master_axi_arvalid(b_m_arvalid), .master_axi_arready(b_m_arready),
        .master_axi_rdata(b_m_rdata), .master_axi_rid(b_m_rid), .master_axi_rlast(b_m_rlast),
        .master_axi_rvalid(b_m_rvalid), .master_axi_rready(b_m_rready),
        .free_credits(b_free), .outstanding(b_out), .len_err(b_len_err), .id_err(b_id_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1;
        a_m_rvalid = 1'b0;
        a_s_rready = 1'b0;
        a_s_arvalid = 1'b0;
        tick();
        a_rst = 1'b0;
        tick();
    endtask

    // One cut-through burst on u_cut: issue, fill with rready low, then drain and check order.
    task automatic burst_a(input logic [7:0] len, input logic [3:0] id, input logic [8:0] exp_free);
        int errs;
        errs = 0;
        chk("a_arready_idle", a_s_arready, 1);
        a_s_araddr = 32'h1000_0000 | {24'h0, len};
        a_s_arlen = len;
        a_s_arid = id;
        a_s_arvalid = 1'b1;
        tick();
        a_s_arvalid = 1'b0;
        chk("a_arvalid_t1", a_m_arvalid, 1);
        chk("a_arlen_out", a_m_arlen, len);
        chk("a_arid_out", a_m_arid, id);
        chk("a_araddr_out", a_m_araddr, 32'h1000_0000 | {24'h0, len});
        tick();
        chk("a_free_issued", a_free, exp_free);
        chk("a_out_issued", a_out, 1);
        for (int i = 0; i <= int'(len); i++) begin
            a_m_rdata = 32'hD000_0000 + i;
            a_m_rid = id;
            a_m_rlast = (i == int'(len));
            a_m_rvalid = 1'b1;
            if (a_m_rready !== 1'b1) errs++;
            tick();
            if (i == 0) chk("a_cut_rvalid_t1", a_s_rvalid, 1);
        end
        a_m_rvalid = 1'b0;
        a_m_rlast = 1'b0;
        chk("a_out_done", a_out, 0);
        chk("a_free_hold", a_free, exp_free);
        a_s_rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            if (a_s_rvalid !== 1'b1 || a_s_rdata !== 32'hD000_0000 + i || a_s_rid !== id
                || a_s_rlast !== (i == int'(len))) errs++;
            tick();
        end
        a_s_rready = 1'b0;
        chk("a_burst_beats", errs, 0);
        chk("a_free_back", a_free, 256);
        chk("a_rvalid_drained", a_s_rvalid, 0);
    endtask

    typedef struct {
        logic [7:0] len;
        logic [3:0] id;
        logic [8:0] exp_free;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int errs;
        vecs[0] = '{len: 8'd7,   id: 4'd3,  exp_free: 9'd248};
        vecs[1] = '{len: 8'd0,   id: 4'd9,  exp_free: 9'd255};
        vecs[2] = '{len: 8'd15,  id: 4'd12, exp_free: 9'd240};
        vecs[3] = '{len: 8'd255, id: 4'd6,  exp_free: 9'd0};

        #1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        chk("rst_a_arready", a_s_arready, 0);
        chk("rst_a_rready", a_m_rready, 0);
        chk("rst_a_rvalid", a_s_rvalid, 0);
        chk("rst_a_arvalid", a_m_arvalid, 0);
        chk("rst_a_free", a_free, 256);
        chk("rst_a_out", a_out, 0);
        chk("rst_a_errs", {a_len_err, a_id_err}, 0);
        chk("rst_a_payload", {a_m_araddr, a_s_rdata}, 0);
        chk("rst_b_free", b_free, 16);
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk("a_arready_at_deassert", a_s_arready, 0);
        tick();
        chk("a_arready_rise", a_s_arready, 1);
        chk("a_rready_rise", a_m_rready, 1);
        chk("b_arready_rise", b_s_arready, 1);

        for (int k = 0; k < 4; k++) burst_a(vecs[k].len, vecs[k].id, vecs[k].exp_free);

        // Return order differs from issue order: id_err sets on the first beat and sticks.
        a_s_arlen = 8'd0;
        a_s_arid = 4'd1;
        a_s_arvalid = 1'b1;
        tick();
        a_s_arid = 4'd2;
        tick();
        a_s_arvalid = 1'b0;
        tick();
        tick();
        chk("a_two_issued", a_out, 2);
        chk("a_two_free", a_free, 254);
        chk("a_id_err_pre", a_id_err, 0);
        a_m_rid = 4'd2;
        a_m_rlast = 1'b1;
        a_m_rvalid = 1'b1;
        tick();
        chk("a_id_err_set", a_id_err, 1);
        a_m_rid = 4'd1;
        tick();
        a_m_rvalid = 1'b0;
        a_m_rlast = 1'b0;
        tick();
        chk("a_id_err_sticky", a_id_err, 1);
        reset_a();
        chk("a_id_err_cleared", a_id_err, 0);

        // Five single-beat ARs with no R return: only AR_DEPTH may be outstanding.
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_s_arready !== 1'b1) errs++;
            a_s_arlen = 8'd0;
            a_s_arid = 4'(i);
            a_s_arvalid = 1'b1;
            tick();
        end
        a_s_arvalid = 1'b0;
        repeat (4) tick();
        chk("a_ol_push_ready", errs, 0);
        chk("a_ol_outstanding", a_out, 4);
        chk("a_ol_arvalid_held", a_m_arvalid, 0);
        chk("a_ol_free", a_free, 252);
        reset_a();

        // Asynchronous reset in the middle of an 8-beat burst.
        a_s_arlen = 8'd7;
        a_s_arid = 4'd5;
        a_s_arvalid = 1'b1;
        tick();
        a_s_arvalid = 1'b0;
        tick();
        a_s_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_m_rdata = 32'hE000_0000 + i;
            a_m_rid = 4'd5;
            a_m_rlast = 1'b0;
            a_m_rvalid = 1'b1;
            tick();
        end
        chk("a_mid_rvalid", a_s_rvalid, 1);
        #3;
        a_rst = 1'b1;
        #1;
        chk("a_mid_rst_ready", {a_s_arready, a_m_rready}, 0);
        chk("a_mid_rst_valid", {a_s_rvalid, a_m_arvalid}, 0);
        chk("a_mid_rst_rdata", a_s_rdata, 0);
        chk("a_mid_rst_free", a_free, 256);
        chk("a_mid_rst_out", a_out, 0);
        a_m_rvalid = 1'b0;
        a_s_rready = 1'b0;
        tick();
        a_rst = 1'b0;
        tick();
        burst_a(8'd7, 4'd3, 9'd248);

        // Store-and-forward: rvalid waits for rlast, then the burst drains back-to-back.
        b_s_araddr = 32'h40;
        b_s_arlen = 8'd3;
        b_s_arid = 4'd4;
        b_s_arvalid = 1'b1;
        tick();
        b_s_arvalid = 1'b0;
        chk("b_arvalid_t1", b_m_arvalid, 1);
        tick();
        chk("b_free_issued", b_free, 12);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            b_m_rdata = 32'hB0 + i;
            b_m_rid = 4'd4;
            b_m_rlast = (i == 3);
            b_m_rvalid = 1'b1;
            tick();
            b_m_rvalid = 1'b0;
            b_m_rlast = 1'b0;
            if (i < 3) begin
                if (b_s_rvalid !== 1'b0) errs++;
                tick();
                if (b_s_rvalid !== 1'b0) errs++;
                tick();
                if (b_s_rvalid !== 1'b0) errs++;
            end else begin
                chk("b_store_rvalid_after_rlast", b_s_rvalid, 1);
            end
        end
        chk("b_store_held", errs, 0);
        errs = 0;
        b_s_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b_s_rvalid !== 1'b1 || b_s_rdata !== 32'hB0 + i || b_s_rid !== 4'd4
                || b_s_rlast !== (i == 3)) errs++;
            tick();
        end
        b_s_rready = 1'b0;
        chk("b_store_beats", errs, 0);
        chk("b_store_free_back", b_free, 16);
        chk("b_store_drained", b_s_rvalid, 0);

        // Credit stall: a full-depth burst leaves no room for the next AR until one beat drains.
        b_s_arlen = 8'd15;
        b_s_arid = 4'd1;
        b_s_arvalid = 1'b1;
        tick();
        b_s_arlen = 8'd0;
        b_s_arid = 4'd2;
        tick();
        b_s_arvalid = 1'b0;
        tick();
        tick();
        chk("b_cs_free0", b_free, 0);
        chk("b_cs_stalled", b_m_arvalid, 0);
        chk("b_cs_out1", b_out, 1);
        for (int i = 0; i < 16; i++) begin
            b_m_rdata = 32'hC0 + i;
            b_m_rid = 4'd1;
            b_m_rlast = (i == 15);
            b_m_rvalid = 1'b1;
            tick();
        end
        b_m_rvalid = 1'b0;
        b_m_rlast = 1'b0;
        tick();
        chk("b_cs_still_stalled", b_m_arvalid, 0);
        chk("b_cs_free_still0", b_free, 0);
        chk("b_cs_burst_ready", b_s_rvalid, 1);
        b_s_rready = 1'b1;
        tick();
        b_s_rready = 1'b0;
        chk("b_cs_free1", b_free, 1);
        chk("b_cs_issue", b_m_arvalid, 1);
        chk("b_cs_issue_id", b_m_arid, 2);
        tick();
        chk("b_cs_free_after", b_free, 0);
        chk("b_cs_out_after", b_out, 1);

        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        tick();

        // Oversized burst: flag it and never issue it.
        chk("b_len_err_pre", b_len_err, 0);
        b_s_arlen = 8'd255;
        b_s_arid = 4'd7;
        b_s_arvalid = 1'b1;
        tick();
        b_s_arvalid = 1'b0;
        chk("b_len_err_set", b_len_err, 1);
        errs = 0;
        repeat (6) begin
            if (b_m_arvalid !== 1'b0) errs++;
            tick();
        end
        chk("b_len_never_issues", errs, 0);
        chk("b_len_err_sticky", b_len_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_chk);
        $fatal(1);
    end
endmodule
